// File: rtl/wb_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wb_stage_pkg
//  Description : Shared definitions for the write-back stage. Holds the
//                load-size encodings, the r0 address and the register-file
//                address/data widths. Also defines the layout of one queued
//                mul/div result.
//  Revision    : 1.0 - initial release
// ============================================================================
package wb_stage_pkg;

   localparam int REG_W  = 5;
   localparam int DATA_W = 32;

   localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

   localparam logic [1:0] LD_BYTE = 2'b00;
   localparam logic [1:0] LD_HALF = 2'b01;
   localparam logic [1:0] LD_WORD = 2'b10;

   // One queued mul/div result: destination register plus data (37 bits).
   typedef struct packed {
      logic [REG_W-1:0]  rd;
      logic [DATA_W-1:0] data;
   } md_entry_t;

   localparam int MD_ENTRY_W = REG_W + DATA_W;

endpackage : wb_stage_pkg
`default_nettype wire

// File: rtl/wb_md_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : wb_md_fifo
//  Description : Synchronous DEPTH x WIDTH FIFO for out-of-order mul/div
//                results. The head entry is visible combinationally. A push
//                and a pop in the same cycle are both performed. A push
//                while full is ignored, and so is a pop while empty.
//  Ports       : clk, rst     - clock, synchronous active-high reset
//                i_push/i_din - enqueue request and data
//                i_pop        - dequeue request
//                o_head       - entry at the head of the queue
//                o_count      - number of valid entries
//                o_empty      - queue holds no entries
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_md_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 37
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_push,
   input  logic [WIDTH-1:0]           i_din,
   input  logic                       i_pop,
   output logic [WIDTH-1:0]           o_head,
   output logic [$clog2(DEPTH+1)-1:0] o_count,
   output logic                       o_empty
);

   localparam int c_PTR_W = $clog2(DEPTH);
   localparam int c_CNT_W = $clog2(DEPTH+1);

   logic [WIDTH-1:0]   r_mem [DEPTH];
   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [c_CNT_W-1:0] r_count;

   logic w_full;
   logic w_do_push;
   logic w_do_pop;

   assign w_full    = (r_count == c_CNT_W'(DEPTH));
   assign w_do_push = i_push && !w_full;
   assign w_do_pop  = i_pop && (r_count != '0);

   // Storage carries no reset; validity is tracked by the count alone.
   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_din;
      end
   end

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + c_CNT_W'(1);
            2'b01:   r_count <= r_count - c_CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_head  = r_mem[r_rd_ptr];
   assign o_count = r_count;
   assign o_empty = (r_count == '0);

endmodule : wb_md_fifo
`default_nettype wire

// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : wb_stage
//  Description : Write-back stage. Owns the single register-file write port
//                and merges in-order MEM-stage results with out-of-order
//                mul/div results onto it. Mul/div results are queued or, when
//                the port is free, bypassed straight through. Queued results
//                may wait only so long: at STARVE_LIMIT the MEM stage is
//                stalled for one cycle so the queue head drains.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                mem_*               - MEM-stage instruction and handshake
//                md_*                - mul/div result and handshake
//                r3_wr/r3_addr/r3_din - registered register-file write port
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_stage
   import wb_stage_pkg::*;
#(
   parameter int MD_DEPTH     = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   // MEM stage
   input  logic              mem_valid,
   output logic              mem_ready,
   input  logic              mem_regwrite,
   input  logic [REG_W-1:0]  mem_rd,
   input  logic              mem_memtoreg,
   input  logic [DATA_W-1:0] mem_alu_result,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic [1:0]        mem_ld_size,
   input  logic              mem_ld_unsigned,
   // mul/div unit
   input  logic              md_valid,
   output logic              md_ready,
   input  logic [REG_W-1:0]  md_rd,
   input  logic [DATA_W-1:0] md_result,
   // register-file write port
   output logic              r3_wr,
   output logic [REG_W-1:0]  r3_addr,
   output logic [DATA_W-1:0] r3_din
);

   localparam int c_CNT_W    = $clog2(MD_DEPTH+1);
   localparam int c_STARVE_W = $clog2(STARVE_LIMIT+1);

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   logic                  r_r3_wr;
   logic [REG_W-1:0]      r_r3_addr;
   logic [DATA_W-1:0]     r_r3_din;
   logic [c_STARVE_W-1:0] r_starve_cnt;

   // ---------------------------------------------------------------------
   // Combinational
   // ---------------------------------------------------------------------
   logic                  w_pipe_acc;
   logic                  w_md_acc;
   logic                  w_pipe_wr;
   logic                  w_md_nonzero;
   logic                  w_pop;
   logic                  w_bypass;
   logic                  w_push;
   logic                  w_wr_en;
   logic [REG_W-1:0]      w_wr_addr;
   logic [DATA_W-1:0]     w_wr_data;
   logic [1:0]            w_lane;
   logic [7:0]            w_byte;
   logic [15:0]           w_half;
   logic [DATA_W-1:0]     w_load;
   logic [DATA_W-1:0]     w_pipe_data;
   logic [c_CNT_W-1:0]    w_fifo_count;
   logic                  w_fifo_empty;
   md_entry_t             w_fifo_head;
   md_entry_t             w_fifo_din;

   // Both ready signals depend on registered state only, so neither
   // producer sees a combinational path back from its own valid.
   assign md_ready  = (w_fifo_count < c_CNT_W'(MD_DEPTH));
   assign mem_ready = (r_starve_cnt != c_STARVE_W'(STARVE_LIMIT));

   assign w_pipe_acc   = mem_valid && mem_ready;
   assign w_md_acc     = md_valid && md_ready;
   assign w_pipe_wr    = w_pipe_acc && mem_regwrite && (mem_rd != REG_ZERO);
   assign w_md_nonzero = (md_rd != REG_ZERO);

   // ---------------------------------------------------------------------
   // Load extraction
   // ---------------------------------------------------------------------
   assign w_lane = mem_alu_result[1:0];

   always_comb begin
      w_byte = mem_rdata[7:0];
      case (w_lane)
         2'd0:    w_byte = mem_rdata[7:0];
         2'd1:    w_byte = mem_rdata[15:8];
         2'd2:    w_byte = mem_rdata[23:16];
         default: w_byte = mem_rdata[31:24];
      endcase
   end

   // Halfword alignment ignores lane[0].
   assign w_half = w_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];

   always_comb begin
      w_load = mem_rdata;
      case (mem_ld_size)
         LD_BYTE: w_load = mem_ld_unsigned ? {24'd0, w_byte}
                                           : {{24{w_byte[7]}}, w_byte};
         LD_HALF: w_load = mem_ld_unsigned ? {16'd0, w_half}
                                           : {{16{w_half[15]}}, w_half};
         LD_WORD: w_load = mem_rdata;
         default: w_load = mem_rdata;
      endcase
   end

   assign w_pipe_data = mem_memtoreg ? w_load : mem_alu_result;

   // ---------------------------------------------------------------------
   // Write-port arbitration: pipeline, then queue head, then bypass.
   // ---------------------------------------------------------------------
   always_comb begin
      w_wr_en   = 1'b0;
      w_wr_addr = r_r3_addr;
      w_wr_data = r_r3_din;
      w_pop     = 1'b0;
      w_bypass  = 1'b0;
      if (w_pipe_wr) begin
         w_wr_en   = 1'b1;
         w_wr_addr = mem_rd;
         w_wr_data = w_pipe_data;
      end else if (!w_fifo_empty) begin
         w_wr_en   = 1'b1;
         w_wr_addr = w_fifo_head.rd;
         w_wr_data = w_fifo_head.data;
         w_pop     = 1'b1;
      end else if (w_md_acc && w_md_nonzero) begin
         w_wr_en   = 1'b1;
         w_wr_addr = md_rd;
         w_wr_data = md_result;
         w_bypass  = 1'b1;
      end
   end

   // r0 results are accepted but never queued.
   assign w_push          = w_md_acc && w_md_nonzero && !w_bypass;
   assign w_fifo_din.rd   = md_rd;
   assign w_fifo_din.data = md_result;

   wb_md_fifo #(
      .DEPTH (MD_DEPTH),
      .WIDTH (MD_ENTRY_W)
   ) u_md_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_din   (w_fifo_din),
      .i_pop   (w_pop),
      .o_head  (w_fifo_head),
      .o_count (w_fifo_count),
      .o_empty (w_fifo_empty)
   );

   // ---------------------------------------------------------------------
   // Registered write port; address and data hold while idle.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_r3_wr   <= 1'b0;
         r_r3_addr <= REG_ZERO;
         r_r3_din  <= '0;
      end else begin
         r_r3_wr <= w_wr_en;
         if (w_wr_en) begin
            r_r3_addr <= w_wr_addr;
            r_r3_din  <= w_wr_data;
         end
      end
   end

   // Starve counter: counts cycles the queue head waits without a pop.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_starve_cnt <= '0;
      end else if (w_fifo_empty || w_pop) begin
         r_starve_cnt <= '0;
      end else if (r_starve_cnt != c_STARVE_W'(STARVE_LIMIT)) begin
         r_starve_cnt <= r_starve_cnt + c_STARVE_W'(1);
      end
   end

   assign r3_wr   = r_r3_wr;
   assign r3_addr = r_r3_addr;
   assign r3_din  = r_r3_din;

endmodule : wb_stage
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_stage
//  Description : Self-checking bench for wb_stage. Directed steps followed by
//                a randomized phase, all checked against a queue-based
//                reference model of the write-back rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_stage;

   localparam int MD_DEPTH     = 2;
   localparam int STARVE_LIMIT = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_valid, mem_ready, mem_regwrite, mem_memtoreg, mem_ld_unsigned;
   logic [4:0]  mem_rd;
   logic [31:0] mem_alu_result, mem_rdata;
   logic [1:0]  mem_ld_size;
   logic        md_valid, md_ready;
   logic [4:0]  md_rd;
   logic [31:0] md_result;
   logic        r3_wr;
   logic [4:0]  r3_addr;
   logic [31:0] r3_din;

   always #5 clk = ~clk;

   wb_stage #(
      .MD_DEPTH     (MD_DEPTH),
      .STARVE_LIMIT (STARVE_LIMIT)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .mem_valid       (mem_valid),
      .mem_ready       (mem_ready),
      .mem_regwrite    (mem_regwrite),
      .mem_rd          (mem_rd),
      .mem_memtoreg    (mem_memtoreg),
      .mem_alu_result  (mem_alu_result),
      .mem_rdata       (mem_rdata),
      .mem_ld_size     (mem_ld_size),
      .mem_ld_unsigned (mem_ld_unsigned),
      .md_valid        (md_valid),
      .md_ready        (md_ready),
      .md_rd           (md_rd),
      .md_result       (md_result),
      .r3_wr           (r3_wr),
      .r3_addr         (r3_addr),
      .r3_din          (r3_din)
   );

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state
   typedef struct {
      logic [4:0]  rd;
      logic [31:0] d;
   } ent_t;
   ent_t        q[$];
   int          waited;
   logic        exp_wr;
   logic [4:0]  exp_addr;
   logic [31:0] exp_din;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Load value from byte/half arithmetic on the memory word.
   function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [31:0] data,
                                            input logic [1:0] sz, input logic uns);
      int unsigned lane;
      int unsigned v;
      int unsigned bits;
      lane = addr % 4;
      if (sz == 2'b00) begin
         v = (data >> (8 * lane)) % 256;
         bits = 8;
      end else if (sz == 2'b01) begin
         v = (data >> (16 * (lane / 2))) % 65536;
         bits = 16;
      end else begin
         return data;
      end
      if (!uns && v >= (32'd1 << (bits - 1))) v = v - (32'd1 << bits);
      return v;
   endfunction

   task automatic set_mem(input logic v, input logic rw, input logic [4:0] rd,
                          input logic m2r, input logic [31:0] alu, input logic [31:0] rdata,
                          input logic [1:0] sz, input logic uns);
      mem_valid = v; mem_regwrite = rw; mem_rd = rd; mem_memtoreg = m2r;
      mem_alu_result = alu; mem_rdata = rdata; mem_ld_size = sz; mem_ld_unsigned = uns;
   endtask

   task automatic set_md(input logic v, input logic [4:0] rd, input logic [31:0] res);
      md_valid = v; md_rd = rd; md_result = res;
   endtask

   task automatic set_idle();
      set_mem(1'b0, 1'b0, 5'd0, 1'b0, 32'd0, 32'd0, 2'b10, 1'b0);
      set_md(1'b0, 5'd0, 32'd0);
   endtask

   // One clock: check readies, predict the edge, then check the write port.
   task automatic cycle();
      int   pre_size;
      logic e_mdr, e_mr, pacc, macc, pwr, popped, byp;
      pre_size = q.size();
      e_mdr = (pre_size < MD_DEPTH);
      e_mr  = (waited != STARVE_LIMIT);
      chk("md_ready", 32'(md_ready), 32'(e_mdr));
      chk("mem_ready", 32'(mem_ready), 32'(e_mr));
      pacc = mem_valid && e_mr;
      macc = md_valid && e_mdr;
      pwr  = pacc && mem_regwrite && (mem_rd != 5'd0);
      popped = 1'b0;
      byp    = 1'b0;
      exp_wr = 1'b0;
      if (pwr) begin
         exp_wr = 1'b1; exp_addr = mem_rd;
         exp_din = mem_memtoreg ? ref_load(mem_alu_result, mem_rdata, mem_ld_size, mem_ld_unsigned)
                                : mem_alu_result;
      end else if (pre_size > 0) begin
         exp_wr = 1'b1; exp_addr = q[0].rd; exp_din = q[0].d;
         void'(q.pop_front());
         popped = 1'b1;
      end else if (macc && md_rd != 5'd0) begin
         exp_wr = 1'b1; exp_addr = md_rd; exp_din = md_result;
         byp = 1'b1;
      end
      if (macc && md_rd != 5'd0 && !byp) q.push_back('{rd: md_rd, d: md_result});
      if (pre_size == 0 || popped) waited = 0;
      else if (waited < STARVE_LIMIT) waited++;
      @(posedge clk);
      #1;
      chk("r3_wr", 32'(r3_wr), 32'(exp_wr));
      chk("r3_addr", 32'(r3_addr), 32'(exp_addr));
      chk("r3_din", r3_din, exp_din);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      q.delete();
      waited = 0; exp_wr = 1'b0; exp_addr = 5'd0; exp_din = 32'd0;
      chk("rst_r3_wr", 32'(r3_wr), 32'd0);
      chk("rst_r3_addr", 32'(r3_addr), 32'd0);
      chk("rst_r3_din", r3_din, 32'd0);
      chk("rst_md_ready", 32'(md_ready), 32'd1);
      chk("rst_mem_ready", 32'(mem_ready), 32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      set_idle();
      waited = 0;
      #1;
      do_reset();

      // 1. ALU write, single-cycle pulse
      set_mem(1'b1, 1'b1, 5'd5, 1'b0, 32'h12345678, 32'd0, 2'b10, 1'b0);
      cycle();
      chk("t1_wr", 32'(r3_wr), 32'd1);
      chk("t1_addr", 32'(r3_addr), 32'd5);
      chk("t1_din", r3_din, 32'h12345678);
      set_idle();
      cycle();
      chk("t1_wr_drop", 32'(r3_wr), 32'd0);

      // 2. Load extraction
      set_mem(1'b1, 1'b1, 5'd6, 1'b1, 32'h00001002, 32'h80FF7F01, 2'b00, 1'b0);
      cycle();
      chk("t2_sb2", r3_din, 32'hFFFFFFFF);
      set_mem(1'b1, 1'b1, 5'd7, 1'b1, 32'h00001002, 32'h80FF7F01, 2'b01, 1'b1);
      cycle();
      chk("t2_uh2", r3_din, 32'h000080FF);
      set_mem(1'b1, 1'b1, 5'd8, 1'b1, 32'h00001001, 32'h80FF7F01, 2'b00, 1'b0);
      cycle();
      chk("t2_sb1", r3_din, 32'h0000007F);

      // 3. Bypass, then contention with the pipeline
      set_idle();
      set_md(1'b1, 5'd9, 32'hA5A5A5A5);
      cycle();
      chk("t3_byp_addr", 32'(r3_addr), 32'd9);
      chk("t3_byp_din", r3_din, 32'hA5A5A5A5);
      set_mem(1'b1, 1'b1, 5'd3, 1'b0, 32'h33333333, 32'd0, 2'b10, 1'b0);
      cycle();
      chk("t3_pipe_first", 32'(r3_addr), 32'd3);
      set_idle();
      cycle();
      chk("t3_md_second", 32'(r3_addr), 32'd9);
      chk("t3_md_second_din", r3_din, 32'hA5A5A5A5);

      // 4. Starvation with back-to-back pipeline writes
      set_mem(1'b1, 1'b1, 5'd1, 1'b0, 32'h100, 32'd0, 2'b10, 1'b0);
      set_md(1'b1, 5'd10, 32'h0A0A0A0A);
      cycle();
      set_md(1'b1, 5'd11, 32'h0B0B0B0B);
      cycle();
      set_md(1'b0, 5'd0, 32'd0);
      chk("t4_md_ready_low", 32'(md_ready), 32'd0);
      for (int i = 0; i < 3; i++) begin
         mem_rd = 5'(2 + i);
         cycle();
         chk("t4_pipe_wins", 32'(r3_addr), 32'(2 + i));
      end
      chk("t4_mem_ready_low", 32'(mem_ready), 32'd0);
      cycle();
      chk("t4_drain_addr", 32'(r3_addr), 32'd10);
      chk("t4_mem_ready_back", 32'(mem_ready), 32'd1);
      set_idle();
      repeat (2) cycle();

      // 5. r0 suppression on both sources
      set_mem(1'b1, 1'b1, 5'd0, 1'b0, 32'hDEADBEEF, 32'd0, 2'b10, 1'b0);
      set_md(1'b1, 5'd0, 32'hCAFEF00D);
      repeat (2) begin
         cycle();
         chk("t5_no_wr", 32'(r3_wr), 32'd0);
         chk("t5_md_ready", 32'(md_ready), 32'd1);
      end

      // 6. Reset with two queued entries
      set_mem(1'b1, 1'b1, 5'd12, 1'b0, 32'h12, 32'd0, 2'b10, 1'b0);
      set_md(1'b1, 5'd20, 32'h20202020);
      cycle();
      set_md(1'b1, 5'd21, 32'h21212121);
      cycle();
      chk("t6_full", 32'(md_ready), 32'd0);
      set_idle();
      do_reset();
      repeat (4) begin
         cycle();
         chk("t6_no_ghost", 32'(r3_wr), 32'd0);
      end

      // Randomized phase
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 199) == 0) begin
            do_reset();
         end else begin
            set_mem($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 9,
                    ($urandom_range(0, 15) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                    1'($urandom_range(0, 1)), $urandom, $urandom,
                    2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            set_md($urandom_range(0, 9) < 5,
                   ($urandom_range(0, 15) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                   $urandom);
            cycle();
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_wb_stage
`default_nettype wire

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Write-back stage. Owns the sole register-file write port (r3_addr / r3_wr / r3_din) that the decode stage's register file consumes.
- Merges two result sources onto that port:
  - in-order results from the MEM stage (ALU or load data, with load byte/half extraction);
  - out-of-order results from the multi-cycle mul/div unit, queued in a small FIFO.
- Drives a registered, single-write-per-cycle stream into the register file.

Parameters:
- MD_DEPTH, 2, mul/div result FIFO entries (power of two, >=2).
- STARVE_LIMIT, 4, cycles a queued mul/div result may wait before the stage forces a drain.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- mem_valid  in  1  MEM stage presents an instruction.
- mem_ready  out  1  stage accepts the MEM instruction this cycle.
- mem_regwrite  in  1  instruction writes a register.
- mem_rd  in  5  destination register.
- mem_memtoreg  in  1  1 = load data, 0 = ALU result.
- mem_alu_result  in  32  ALU result / load address.
- mem_rdata  in  32  raw data-memory word.
- mem_ld_size  in  2  00 byte, 01 half, 10 word.
- mem_ld_unsigned  in  1  zero-extend (1) or sign-extend (0).
- md_valid  in  1  mul/div result available.
- md_ready  out  1  FIFO can accept.
- md_rd  in  5  mul/div destination.
- md_result  in  32  mul/div result.
- r3_wr  out  1  register-file write enable.
- r3_addr  out  5  write address.
- r3_din  out  32  write data.

Behaviour:
- Reset (rst=1 at clk edge):
  - r3_wr=0, r3_addr=0, r3_din=0.
  - FIFO empty; starve counter = 0.
  - Outputs are registered; in-flight inputs during reset are discarded.
- Handshakes:
  - pipe_acc = mem_valid & mem_ready.
  - md_acc = md_valid & md_ready.
  - md_ready = (fifo_count < MD_DEPTH), combinational from state only.
  - mem_ready = !(starve_cnt == STARVE_LIMIT).
- pipe_wr = pipe_acc & mem_regwrite & (mem_rd != 0). Writes to r0 are always suppressed, from either source.
- Load extraction uses byte lane mem_alu_result[1:0]:
  - byte: mem_rdata[8*lane+7 : 8*lane].
  - half: lane[1] selects the upper/lower 16 bits; lane[0] is ignored.
  - word: the full word.
  - Extension per mem_ld_unsigned.
  - ALU path passes mem_alu_result unchanged.
- Per-edge write select, first match wins:
  1. pipe_wr -> write the pipeline result.
  2. FIFO non-empty -> write FIFO head and pop.
  3. md_acc with FIFO empty and md_rd != 0 -> bypass: write md_result directly, no push.
  4. Otherwise r3_wr=0 next cycle; r3_addr and r3_din hold.
- Push: md_acc with md_rd != 0 that is not bypassed enters the FIFO tail. A push and a pop in the same cycle are both legal.
- md_rd == 0 results are accepted and dropped.
- Latency:
  - accepted MEM instruction at edge N -> r3_wr=1 during cycle N+1, for exactly one cycle;
  - mul/div result: 1 cycle when bypassed, otherwise when drained.
- Starve counter:
  - increments each cycle the FIFO is non-empty and no pop occurs;
  - saturates at STARVE_LIMIT;
  - clears on pop or when the FIFO is empty.
  - At STARVE_LIMIT, mem_ready=0, so a pop is guaranteed that cycle.
- Ordering:
  - the pipeline wins a same-cycle conflict on the port;
  - RAW/WAW ordering between the two sources is owned by the hazard unit, not this block.
- Full FIFO: md_ready=0; a same-cycle pop does not raise md_ready. This is a conservative, timing-safe rule.
- Reset mid-drain: queued results are lost. The mul/div unit is reset by the same rst.

Decomposition:
- Shared package holds:
  - load-size encodings LD_BYTE / LD_HALF / LD_WORD;
  - REG_ZERO = 5'd0;
  - register-address and data widths.
- One natural sub-module: wb_md_fifo. It is a synchronous MD_DEPTH x 37-bit FIFO with push/pop/count/head.
- Load extraction and arbitration stay inline in wb_stage.

Test Plan:
1. Reset, then an ALU write: mem_valid=1, rd=5, memtoreg=0, alu=0x12345678. Next cycle r3_wr=1, r3_addr=5, r3_din=0x12345678. The cycle after, r3_wr=0.
2. Loads with rdata=0x80FF7F01:
   - signed byte at addr ...02 -> 0xFFFFFFFF;
   - unsigned half at addr ...02 -> 0x000080FF;
   - signed byte at addr ...01 -> 0x0000007F.
3. Bypass and contention:
   - idle pipeline, md_valid, rd=9, result=0xA5A5A5A5 -> written next cycle;
   - same with a concurrent pipeline write to rd=3 -> rd=3 written first, rd=9 the following cycle.
4. Starvation: fill the FIFO (rd=10, rd=11) while mem_valid=1 with writes every cycle.
   - md_ready drops;
   - after 4 waiting cycles mem_ready=0 for one cycle and rd=10 is written.
5. r0 suppression: pipeline rd=0 and md_rd=0 produce no r3_wr assertion. md_ready stays 1.
6. Reset with 2 queued entries: FIFO empties, r3_wr=0, no queued write appears afterwards.
